// File: rtl/sd_req_arbiter_pkg.sv
// sd_req_arbiter shared types.
// FSM state encoding and the LBA width used by every client.
package sd_arb_pkg;

    localparam int LBA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } sd_arb_state_t;

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Client-side and hps_io-side signal bundle of the disk channel arbiter.
// slave = arbiter view, master = environment (clients + hps_io) view.
interface sd_req_arbiter_if
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]       req_rd;
    logic [NREQ-1:0]       req_wr;
    logic [LBA_W*NREQ-1:0] req_lba;
    logic [NREQ-1:0]       req_busy;
    logic [NREQ-1:0]       req_done;
    logic [NREQ-1:0]       req_err;
    logic [NREQ-1:0]       req_buff_wr;
    logic [8*NREQ-1:0]     req_buff_din;
    logic [LBA_W-1:0]      sd_lba;
    logic [NREQ-1:0]       sd_rd;
    logic [NREQ-1:0]       sd_wr;
    logic [NREQ-1:0]       sd_ack;
    logic                  sd_buff_wr;
    logic [7:0]            sd_buff_din;

    modport slave (
        input  req_rd, req_wr, req_lba, req_buff_din,
        input  sd_ack, sd_buff_wr,
        output req_busy, req_done, req_err, req_buff_wr,
        output sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport master (
        output req_rd, req_wr, req_lba, req_buff_din,
        output sd_ack, sd_buff_wr,
        input  req_busy, req_done, req_err, req_buff_wr,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din
    );

endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index above last_i,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   last_i,
    output logic [IW-1:0]   grant_o,
    output logic            any_o
);

    logic [IW-1:0] sel;

    // Walk from farthest to nearest so the nearest valid index wins.
    always_comb begin
        grant_o = '0;
        sel     = '0;
        any_o   = |valid_i;
        for (int k = NREQ; k >= 1; k--) begin
            sel = IW'((int'(last_i) + k) % NREQ);
            if (valid_i[sel]) grant_o = sel;
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares one hps_io virtual-disk channel among NREQ block clients
// with round-robin fairness, timeout and granted-only buffer routing.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic            clk21m,
    input  logic            rstn,
    sd_req_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sd_arb_state_t    state_q, state_d;
    logic [IW-1:0]    g_q, g_d;
    logic [IW-1:0]    last_q, last_d;
    logic             err_q, err_d;
    logic [23:0]      tmr_q, tmr_d;
    logic [LBA_W-1:0] sd_lba_q, sd_lba_d;
    logic [NREQ-1:0]  rd_q, rd_d;
    logic [NREQ-1:0]  wr_q, wr_d;
    logic [NREQ-1:0]  vld_q, vld_d;
    logic [NREQ-1:0]  dir_q, dir_d;
    logic [LBA_W-1:0] plba_q [NREQ];
    logic [LBA_W-1:0] plba_d [NREQ];

    logic [IW-1:0]    pick;
    logic             any;
    logic [NREQ-1:0]  pick_oh;
    logic [NREQ-1:0]  g_oh;
    logic             fin;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid_i (vld_q),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (any)
    );

    assign pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    assign g_oh    = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
    assign fin     = (state_q == DONE);

    // A strobe in the finishing client's DONE cycle re-arms it (set beats clear).
    always_comb begin
        vld_d  = vld_q;
        dir_d  = dir_q;
        plba_d = plba_q;
        for (int i = 0; i < NREQ; i++) begin
            if (fin && g_q == IW'(i)) vld_d[i] = 1'b0;
            if ((bus.req_rd[i] || bus.req_wr[i]) &&
                (!vld_q[i] || (fin && g_q == IW'(i)))) begin
                vld_d[i]  = 1'b1;
                dir_d[i]  = !bus.req_rd[i];
                plba_d[i] = bus.req_lba[LBA_W*i +: LBA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        err_d    = err_q;
        tmr_d    = tmr_q;
        sd_lba_d = sd_lba_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    g_d      = pick;
                    sd_lba_d = plba_q[pick];
                    rd_d     = dir_q[pick] ? '0 : pick_oh;
                    wr_d     = dir_q[pick] ? pick_oh : '0;
                    tmr_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tmr_d = tmr_q + 24'd1;
                if (bus.sd_ack[g_q]) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = XFER;
                end else if (tmr_q == TIMEOUT - 24'd1) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            XFER: begin
                if (!bus.sd_ack[g_q]) state_d = DONE;
            end
            DONE: begin
                last_d  = g_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            g_q      <= '0;
            last_q   <= IW'(NREQ - 1);
            err_q    <= 1'b0;
            tmr_q    <= '0;
            sd_lba_q <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            vld_q    <= '0;
            dir_q    <= '0;
            for (int i = 0; i < NREQ; i++) plba_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_q   <= last_d;
            err_q    <= err_d;
            tmr_q    <= tmr_d;
            sd_lba_q <= sd_lba_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            vld_q    <= vld_d;
            dir_q    <= dir_d;
            plba_q   <= plba_d;
        end
    end

    assign bus.req_busy    = vld_q;
    assign bus.req_done    = fin ? g_oh : '0;
    assign bus.req_err     = (fin && err_q) ? g_oh : '0;
    assign bus.req_buff_wr = (state_q == XFER && bus.sd_buff_wr) ? g_oh : '0;
    assign bus.sd_buff_din = (state_q == XFER) ?
                             bus.req_buff_din[{g_q, 3'b000} +: 8] : 8'h00;
    assign bus.sd_lba      = sd_lba_q;
    assign bus.sd_rd       = rd_q;
    assign bus.sd_wr       = wr_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: a small hps_io model drives
// ack/buffer traffic while a monitor checks grants and completions.
module tb_sd_req_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] lba;
        bit          err;
    } exp_t;

    logic clk21m = 1'b0;
    logic rstn   = 1'b0;

    always #5 clk21m = ~clk21m;

    sd_req_arbiter_if #(.NREQ(NREQ)) bus();

    sd_req_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (24'd100)
    ) dut (
        .clk21m (clk21m),
        .rstn   (rstn),
        .bus    (bus)
    );

    exp_t            exp_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              done_cnt[NREQ];
    int              bcnt[NREQ];
    logic [7:0]      din_tab[NREQ] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
    logic [NREQ-1:0] prev_cmd = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input bit wr,
                        input logic [31:0] lba, input bit err);
        exp_t e;
        e.idx = idx;
        e.wr  = wr;
        e.lba = lba;
        e.err = err;
        exp_q.push_back(e);
    endtask

    function automatic int done_sum();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += done_cnt[i];
        return s;
    endfunction

    // Monitor: check each new command and each completion against the queue.
    always @(negedge clk21m) begin : mon
        logic [NREQ-1:0] cmd;
        exp_t e;
        cmd = bus.sd_rd | bus.sd_wr;
        if (rstn) begin
            if (cmd != '0 && prev_cmd == '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_issue", cmd, 0);
                end else begin
                    e = exp_q[0];
                    chk("issue_rd", bus.sd_rd, e.wr ? 64'd0 : 64'd1 << e.idx);
                    chk("issue_wr", bus.sd_wr, e.wr ? 64'd1 << e.idx : 64'd0);
                    chk("issue_lba", bus.sd_lba, e.lba);
                end
            end
            if (bus.req_done != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_done", bus.req_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_idx", bus.req_done, 64'd1 << e.idx);
                    chk("done_err", bus.req_err, e.err ? 64'd1 << e.idx : 64'd0);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_done[i]) done_cnt[i]++;
                if (bus.req_buff_wr[i]) bcnt[i]++;
            end
        end
        prev_cmd = cmd;
    end

    task automatic strobe(input logic [NREQ-1:0] rd, input logic [NREQ-1:0] wr,
                          input logic [31:0] base);
        @(posedge clk21m);
        #1;
        bus.req_rd = rd;
        bus.req_wr = wr;
        for (int i = 0; i < NREQ; i++) bus.req_lba[32*i +: 32] = base + 32'(i);
        @(posedge clk21m);
        #1;
        bus.req_rd  = '0;
        bus.req_wr  = '0;
        bus.req_lba = '1;
    endtask

    task automatic wait_cmd(output int g, output bit ok);
        ok = 1'b0;
        g  = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk21m);
            if ((bus.sd_rd | bus.sd_wr) != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cmd_wait", 0, 1);
        for (int i = 0; i < NREQ; i++) if (bus.sd_rd[i] || bus.sd_wr[i]) g = i;
    endtask

    task automatic serve(input int nbuf);
        int g;
        bit ok;
        wait_cmd(g, ok);
        if (!ok) return;
        chk("issue_din", bus.sd_buff_din, 0);
        repeat (5) @(posedge clk21m);
        #1 bus.sd_ack[g] = 1'b1;
        @(posedge clk21m);
        @(negedge clk21m);
        chk("rd_drop", bus.sd_rd | bus.sd_wr, 0);
        for (int n = 0; n < nbuf; n++) begin
            @(posedge clk21m);
            #1 bus.sd_buff_wr = 1'b1;
            @(negedge clk21m);
            if (n == 0) begin
                chk("xfer_din", bus.sd_buff_din, din_tab[g]);
                chk("bwr_gate", bus.req_buff_wr, 64'd1 << g);
            end
            @(posedge clk21m);
            #1 bus.sd_buff_wr = 1'b0;
        end
        @(posedge clk21m);
        #1 bus.sd_ack[g] = 1'b0;
        @(posedge clk21m);
        @(negedge clk21m);
        chk("done_lat", bus.req_done, 64'd1 << g);
        @(negedge clk21m);
        chk("post_din", bus.sd_buff_din, 0);
    endtask

    task automatic do_reset();
        @(posedge clk21m);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk21m);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        bit ok;
        int d0;
        int cnt;
        bus.req_rd     = '0;
        bus.req_wr     = '0;
        bus.req_lba    = '0;
        bus.sd_ack     = '0;
        bus.sd_buff_wr = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_buff_din[8*i +: 8] = din_tab[i];

        // reset state
        repeat (2) @(negedge clk21m);
        chk("rst_busy", bus.req_busy, 0);
        chk("rst_cmd", {bus.sd_rd, bus.sd_wr}, 0);
        chk("rst_lba", bus.sd_lba, 0);
        chk("rst_done", {bus.req_done, bus.req_err}, 0);
        chk("rst_din", bus.sd_buff_din, 0);
        @(posedge clk21m);
        #1 rstn = 1'b1;

        // single read, client 1
        strobe(4'b0010, 4'b0000, 32'h122);
        push(1, 1'b0, 32'h123, 1'b0);
        @(negedge clk21m);
        chk("t1_busy", bus.req_busy, 4'b0010);
        chk("t1_rd_early", bus.sd_rd, 0);
        @(negedge clk21m);
        chk("t1_rd", bus.sd_rd, 4'b0010);
        serve(512);
        chk("t1_bwr_cnt", bcnt[1], 512);
        chk("t1_bwr_other", bcnt[0] + bcnt[2] + bcnt[3], 0);
        chk("t1_done_cnt", done_cnt[1], 1);

        // round robin from reset, re-strobe of 0 during 2
        do_reset();
        strobe(4'b1101, 4'b0000, 32'h100);
        push(0, 1'b0, 32'h100, 1'b0);
        push(2, 1'b0, 32'h102, 1'b0);
        push(3, 1'b0, 32'h103, 1'b0);
        serve(4);
        strobe(4'b0001, 4'b0000, 32'h110);
        push(0, 1'b0, 32'h110, 1'b0);
        serve(4);
        serve(4);
        serve(4);
        chk("rr_sb", exp_q.size(), 0);

        // write-back, client 0
        strobe(4'b0000, 4'b0001, 32'h50);
        push(0, 1'b1, 32'h50, 1'b0);
        serve(4);

        // timeout on client 2, then client 3 served
        strobe(4'b1100, 4'b0000, 32'h200);
        push(2, 1'b0, 32'h202, 1'b1);
        push(3, 1'b0, 32'h203, 1'b0);
        wait_cmd(g, ok);
        cnt = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk21m);
            if ((bus.sd_rd | bus.sd_wr) == '0) break;
            cnt++;
        end
        chk("to_len", cnt, 100);
        chk("to_done", bus.req_done, 4'b0100);
        chk("to_err", bus.req_err, 4'b0100);
        serve(2);

        // stray ack on 3 and ignored re-strobe while client 1 busy
        strobe(4'b0010, 4'b0000, 32'h776);
        push(1, 1'b0, 32'h777, 1'b0);
        wait_cmd(g, ok);
        @(posedge clk21m);
        #1 bus.sd_ack[3] = 1'b1;
        @(posedge clk21m);
        #1 bus.sd_ack[3] = 1'b0;
        strobe(4'b0010, 4'b0000, 32'h998);
        @(negedge clk21m);
        chk("stray_rd", bus.sd_rd, 4'b0010);
        chk("stray_lba", bus.sd_lba, 32'h777);
        chk("stray_busy", bus.req_busy, 4'b0010);
        d0 = done_cnt[1];
        serve(4);
        repeat (20) @(negedge clk21m);
        chk("stray_one_done", done_cnt[1] - d0, 1);
        chk("stray_idle", bus.req_busy, 0);

        // reset during the data phase of client 2
        strobe(4'b0100, 4'b0000, 32'h2FE);
        push(2, 1'b0, 32'h300, 1'b0);
        wait_cmd(g, ok);
        repeat (3) @(posedge clk21m);
        #1 bus.sd_ack[2] = 1'b1;
        @(posedge clk21m);
        #1 bus.sd_buff_wr = 1'b1;
        @(negedge clk21m);
        chk("rx_bwr", bus.req_buff_wr, 4'b0100);
        chk("rx_din", bus.sd_buff_din, din_tab[2]);
        d0 = done_sum();
        #2 rstn = 1'b0;
        #1;
        chk("rx_busy", bus.req_busy, 0);
        chk("rx_cmd", {bus.sd_rd, bus.sd_wr}, 0);
        chk("rx_bwr0", bus.req_buff_wr, 0);
        chk("rx_din0", bus.sd_buff_din, 0);
        chk("rx_lba0", bus.sd_lba, 0);
        chk("rx_done0", bus.req_done, 0);
        exp_q.delete();
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = '0;
        repeat (2) @(posedge clk21m);
        #1 rstn = 1'b1;
        repeat (4) @(negedge clk21m);
        chk("rx_no_done", done_sum() - d0, 0);
        strobe(4'b1001, 4'b0000, 32'h400);
        push(0, 1'b0, 32'h400, 1'b0);
        push(3, 1'b0, 32'h403, 1'b0);
        serve(2);
        serve(2);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
